// File: rtl/demux4_stream.sv
// Registered 1-to-4 stream demultiplexer: one DEPTH-entry circular FIFO per destination channel,
// independent valid/ready on each output.
module demux4_stream #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_sel,
    input  logic [WIDTH-1:0]     in_data,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [4*WIDTH-1:0]   out_data,
    output logic                 busy
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [CW-1:0]    cnt_q  [4];
    logic [CW-1:0]    cnt_d  [4];
    logic [PW-1:0]    wptr_q [4];
    logic [PW-1:0]    wptr_d [4];
    logic [PW-1:0]    rptr_q [4];
    logic [PW-1:0]    rptr_d [4];
    logic [WIDTH-1:0] mem_q  [4][DEPTH];
    logic [WIDTH-1:0] mem_d  [4][DEPTH];

    logic       push;
    logic [3:0] push_ch;
    logic [3:0] pop_ch;

    // Readiness depends only on registered occupancy of the selected channel, never on out_ready.
    assign in_ready = (cnt_q[in_sel] != CW'(DEPTH));
    assign push     = in_valid & in_ready;

    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int i = 0; i < 4; i++) begin
            out_valid[i]               = (cnt_q[i] != '0);
            out_data[i*WIDTH +: WIDTH] = mem_q[i][rptr_q[i]];
        end
    end

    assign busy = |out_valid;

    always_comb begin
        mem_d   = mem_q;
        push_ch = '0;
        pop_ch  = '0;
        for (int i = 0; i < 4; i++) begin
            push_ch[i] = push && (in_sel == 2'(i));
            pop_ch[i]  = out_valid[i] & out_ready[i];
            cnt_d[i]   = cnt_q[i];
            wptr_d[i]  = wptr_q[i];
            rptr_d[i]  = rptr_q[i];
            if (push_ch[i]) begin
                mem_d[i][wptr_q[i]] = in_data;
                wptr_d[i]           = wptr_q[i] + PW'(1);
            end
            if (pop_ch[i]) begin
                rptr_d[i] = rptr_q[i] + PW'(1);
            end
            if (push_ch[i] && !pop_ch[i]) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else if (!push_ch[i] && pop_ch[i]) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i]  <= '0;
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    mem_q[i][j] <= '0;
                end
            end
        end else begin
            cnt_q  <= cnt_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: tb/tb_demux4_stream.sv
// Self-checking bench for demux4_stream: directed scenarios plus random traffic, all outputs
// compared against per-channel reference queues.
module tb_demux4_stream;

    localparam int unsigned W = 32;
    localparam int unsigned D = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     in_sel;
    logic [W-1:0]   in_data;
    logic [3:0]     out_valid;
    logic [3:0]     out_ready;
    logic [4*W-1:0] out_data;
    logic           busy;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] model_q [4][$];

    demux4_stream #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                         input logic [3:0] r);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] slice(input int i);
        return out_data[i*W +: W];
    endfunction

    always @(negedge rst_n) begin
        for (int i = 0; i < 4; i++) model_q[i].delete();
    end

    // Output monitor: compares the DUT against the reference queues just before each rising edge,
    // then applies the handshakes that will fire on that edge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("out_valid[%0d]", i), 128'(out_valid[i]),
                    128'(model_q[i].size() != 0));
                if (model_q[i].size() != 0)
                    chk($sformatf("out_data[%0d]", i), 128'(slice(i)), 128'(model_q[i][0]));
            end
            chk("in_ready", 128'(in_ready), 128'(model_q[in_sel].size() != D));
            chk("busy", 128'(busy), 128'(model_q[0].size() + model_q[1].size()
                + model_q[2].size() + model_q[3].size() != 0));
            for (int i = 0; i < 4; i++) begin
                if (out_valid[i] && out_ready[i] && model_q[i].size() != 0)
                    void'(model_q[i].pop_front());
            end
            if (in_valid && in_ready) model_q[in_sel].push_back(in_data);
        end
    end

    initial begin
        int sent;
        logic v;

        // Reset with random inputs
        rst_n = 1'b0;
        drive(1'b0, 2'd0, '0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            drive(1'($urandom), 2'($urandom), $urandom, 4'($urandom));
            tick();
            chk("rst out_valid", 128'(out_valid), 128'(0));
            chk("rst busy", 128'(busy), 128'(0));
            chk("rst out_data", 128'(out_data), 128'(0));
        end
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            chk($sformatf("rst in_ready sel%0d", s), 128'(in_ready), 128'(1));
        end
        drive(1'b0, 2'd0, '0, 4'h0);
        #2 rst_n = 1'b1;
        tick();
        chk("post-rst out_valid", 128'(out_valid), 128'(0));

        // Routing
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), W'(32'hA0 + i), 4'h0);
            tick();
        end
        drive(1'b0, 2'd0, '0, 4'h0);
        chk("route out_valid", 128'(out_valid), 128'(4'hF));
        for (int i = 0; i < 4; i++)
            chk($sformatf("route slice%0d", i), 128'(slice(i)), 128'(32'hA0 + i));
        drive(1'b0, 2'd0, '0, 4'hF);
        tick();
        drive(1'b0, 2'd0, '0, 4'h0);
        chk("route drained", 128'(out_valid), 128'(0));

        // Full channel and backpressure
        drive(1'b1, 2'd2, 32'h11, 4'h0);
        tick();
        drive(1'b1, 2'd2, 32'h22, 4'h0);
        tick();
        drive(1'b0, 2'd2, '0, 4'h0);
        #1 chk("full in_ready sel2", 128'(in_ready), 128'(0));
        in_sel = 2'd0;
        #1 chk("full in_ready sel0", 128'(in_ready), 128'(1));
        drive(1'b1, 2'd2, 32'h33, 4'b0100);
        #1 chk("full+pop in_ready", 128'(in_ready), 128'(0));
        tick();
        drive(1'b1, 2'd2, 32'h33, 4'b0000);
        #1 chk("freed in_ready", 128'(in_ready), 128'(1));
        chk("bp head 22", 128'(slice(2)), 128'(32'h22));
        tick();
        drive(1'b0, 2'd0, '0, 4'b0100);
        tick();
        chk("bp head 33", 128'(slice(2)), 128'(32'h33));
        tick();
        drive(1'b0, 2'd0, '0, 4'h0);
        chk("bp drained", 128'(out_valid[2]), 128'(0));

        // Push and pop on the same cycle, then ordered drain with gaps
        drive(1'b1, 2'd1, 32'h40, 4'h0);
        tick();
        drive(1'b1, 2'd1, 32'h41, 4'b0010);
        tick();
        drive(1'b0, 2'd0, '0, 4'h0);
        chk("pp valid", 128'(out_valid[1]), 128'(1));
        chk("pp head", 128'(slice(1)), 128'(32'h41));
        drive(1'b0, 2'd0, '0, 4'b0010);
        tick();
        chk("pp one entry", 128'(out_valid[1]), 128'(0));
        sent = 0;
        for (int k = 0; k < 200 && sent < 10; k++) begin
            v = 1'($urandom);
            drive(v, 2'd1, W'(32'h50 + sent), {2'b00, 1'($urandom), 1'b0});
            #1;
            if (v && in_ready) sent++;
            tick();
        end
        chk("gap words sent", 128'(sent), 128'(10));
        drive(1'b0, 2'd0, '0, 4'b0010);
        repeat (4) tick();
        chk("gap drained", 128'(out_valid[1]), 128'(0));

        // Asynchronous reset while ch3 holds two words
        drive(1'b1, 2'd3, 32'h77, 4'h0);
        tick();
        drive(1'b1, 2'd3, 32'h78, 4'h0);
        tick();
        drive(1'b0, 2'd0, '0, 4'h0);
        chk("ch3 loaded", 128'(out_valid[3]), 128'(1));
        #2 rst_n = 1'b0;
        #1 chk("async rst valid3", 128'(out_valid[3]), 128'(0));
        chk("async rst busy", 128'(busy), 128'(0));
        #5 rst_n = 1'b1;
        tick();
        chk("post async rst", 128'(out_valid), 128'(0));

        // Random traffic
        for (int k = 0; k < 10000; k++) begin
            drive(1'($urandom), 2'($urandom), $urandom, 4'($urandom));
            tick();
        end
        drive(1'b0, 2'd0, '0, 4'hF);
        repeat (D + 2) tick();
        chk("final out_valid", 128'(out_valid), 128'(0));
        chk("final model empty", 128'(model_q[0].size() + model_q[1].size()
            + model_q[2].size() + model_q[3].size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
